// File: rtl/cache_controller.sv
// Cache set sequencer: compares each processor request against one set, then
// writes back a dirty victim and refills the line from memory on a miss.
module cache_controller #(
  parameter int TAG_WIDTH    = 26,
  parameter int INDEX_WIDTH  = 2,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ren_i,
  input  logic                 wen_i,
  input  logic [31:0]          addr_i,
  input  logic                 hit_i,
  input  logic                 dirty_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic                 mem_ready_i,
  output logic [5:0]           control_o,
  output logic [31:0]          mem_addr_o,
  output logic                 mem_ren_o,
  output logic                 mem_wen_o,
  output logic                 ready_o
);

  localparam int CNT_W = OFFSET_WIDTH - 2;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  // control_o = {write_en, update_en, set_valid, set_dirty, strategy_en, offset_sel}
  localparam logic [5:0] CTRL_IDLE     = 6'b000001;
  localparam logic [5:0] CTRL_RD_HIT   = 6'b000011;
  localparam logic [5:0] CTRL_WR_HIT   = 6'b101111;
  localparam logic [5:0] CTRL_FILL     = 6'b010000;
  localparam logic [5:0] CTRL_FILL_END = 6'b011000;

  typedef enum logic [1:0] {
    COMPARE    = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [TAG_WIDTH-1:0] addr_tag;
  logic [INDEX_WIDTH-1:0] addr_idx;
  logic                 cnt_last;
  logic                 unused_addr;

  assign addr_tag    = addr_i[31:32-TAG_WIDTH];
  assign addr_idx    = addr_i[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
  assign cnt_last    = (cnt == CNT_LAST);
  assign unused_addr = ^addr_i[OFFSET_WIDTH-1:0];

  function automatic logic [31:0] word_addr(input logic [TAG_WIDTH-1:0]   tag,
                                            input logic [INDEX_WIDTH-1:0] idx,
                                            input logic [CNT_W-1:0]       word);
    return {tag, idx, word, 2'b00};
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= COMPARE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    control_o  = '0;
    mem_addr_o = {addr_i[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    mem_ren_o  = 1'b0;
    mem_wen_o  = 1'b0;
    ready_o    = 1'b0;

    case (state)
      COMPARE: begin
        control_o = CTRL_IDLE;
        if (wen_i && hit_i) begin
          control_o = CTRL_WR_HIT;
          ready_o   = 1'b1;
        end else if (ren_i && hit_i) begin
          control_o = CTRL_RD_HIT;
          ready_o   = 1'b1;
        end else if (wen_i || ren_i) begin
          cnt_next   = '0;
          state_next = dirty_i ? WRITE_BACK : ALLOCATE;
        end
      end

      // Victim address comes from the set's stored tag; strategy stays frozen.
      WRITE_BACK: begin
        mem_addr_o = word_addr(tag_i, addr_idx, cnt);
        mem_wen_o  = 1'b1;
        if (mem_ready_i) begin
          cnt_next = cnt + 1'b1;
          if (cnt_last) state_next = ALLOCATE;
        end
      end

      // Line only becomes valid with its last word, so no early hit is seen.
      ALLOCATE: begin
        mem_addr_o = word_addr(addr_tag, addr_idx, cnt);
        mem_ren_o  = 1'b1;
        if (mem_ready_i) begin
          control_o = cnt_last ? CTRL_FILL_END : CTRL_FILL;
          cnt_next  = cnt + 1'b1;
          if (cnt_last) state_next = COMPARE;
        end
      end

      default: state_next = COMPARE;
    endcase

    if (rst_i) begin
      control_o  = '0;
      mem_addr_o = '0;
      mem_ren_o  = 1'b0;
      mem_wen_o  = 1'b0;
      ready_o    = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: direct compare-cycle checks plus a
// queue of expected memory transfers popped on every memory handshake.
module tb_cache_controller;

  logic        clk_i = 1'b0;
  logic        rst_i, ren_i, wen_i, hit_i, dirty_i, mem_ready_i;
  logic [31:0] addr_i;
  logic [25:0] tag_i;
  logic [5:0]  control_o;
  logic [31:0] mem_addr_o;
  logic        mem_ren_o, mem_wen_o, ready_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [5:0]  ctrl;
  } xfer_t;

  xfer_t exp_q[$];

  cache_controller #(.TAG_WIDTH(26), .INDEX_WIDTH(2), .OFFSET_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ren_i(ren_i), .wen_i(wen_i), .addr_i(addr_i),
    .hit_i(hit_i), .dirty_i(dirty_i), .tag_i(tag_i), .mem_ready_i(mem_ready_i),
    .control_o(control_o), .mem_addr_o(mem_addr_o), .mem_ren_o(mem_ren_o),
    .mem_wen_o(mem_wen_o), .ready_o(ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic wr, input logic [31:0] addr, input logic [5:0] ctrl);
    xfer_t e;
    e.wr = wr; e.addr = addr; e.ctrl = ctrl;
    exp_q.push_back(e);
  endtask

  task automatic push_fill(input logic [31:0] base);
    for (int w = 0; w < 4; w++)
      push(1'b0, base + 32'(w * 4), (w == 3) ? 6'b011000 : 6'b010000);
  endtask

  // Drives mem_ready until nwords handshakes are seen; leaves us at posedge+1.
  task automatic run_transfer(input int nwords, input int budget, input bit every_other);
    int n = 0;
    for (int i = 0; i < budget && n < nwords; i++) begin
      mem_ready_i = every_other ? logic'(i % 2) : 1'b1;
      @(negedge clk_i);
      chk("strobe", 32'(mem_ren_o | mem_wen_o), 32'd1);
      if (!mem_ready_i) chk("ctrl_wait", 32'(control_o), 32'd0);
      if (mem_ready_i && (mem_ren_o || mem_wen_o)) n++;
      step();
    end
    mem_ready_i = 1'b0;
    if (n < nwords) chk("xfer_timeout", 32'(n), 32'(nwords));
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && (mem_ren_o || mem_wen_o) && mem_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", mem_addr_o, 32'hFFFF_FFFF);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        chk("xfer_wr", 32'(mem_wen_o), 32'(e.wr));
        chk("xfer_rd", 32'(mem_ren_o), 32'(!e.wr));
        chk("xfer_addr", mem_addr_o, e.addr);
        chk("xfer_ctrl", 32'(control_o), 32'(e.ctrl));
      end
    end
  end

  initial begin
    rst_i = 1'b1; ren_i = 1'b1; wen_i = 1'b0; hit_i = 1'b0; dirty_i = 1'b0;
    mem_ready_i = 1'b0; addr_i = '0; tag_i = '0;

    repeat (2) begin
      @(negedge clk_i);
      chk("rst_ctrl", 32'(control_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd0);
      chk("rst_mem_ren", 32'(mem_ren_o), 32'd0);
    end
    step();
    rst_i = 1'b0; ren_i = 1'b0;
    @(negedge clk_i);
    chk("idle_ctrl", 32'(control_o), 32'h01);
    chk("idle_ready", 32'(ready_o), 32'd0);

    // Read hit and write hits
    step();
    ren_i = 1'b1; addr_i = 32'h0000_0040; hit_i = 1'b1;
    @(negedge clk_i);
    chk("rdhit_ready", 32'(ready_o), 32'd1);
    chk("rdhit_ctrl", 32'(control_o), 32'h03);
    chk("rdhit_strobes", 32'({mem_ren_o, mem_wen_o}), 32'd0);
    chk("rdhit_addr", mem_addr_o, 32'h0000_0040);
    step();
    ren_i = 1'b0; wen_i = 1'b1;
    @(negedge clk_i);
    chk("wrhit_ctrl", 32'(control_o), 32'h2F);
    chk("wrhit_ready", 32'(ready_o), 32'd1);
    step();
    ren_i = 1'b1;
    @(negedge clk_i);
    chk("rwhit_ctrl", 32'(control_o), 32'h2F);
    chk("rwhit_ready", 32'(ready_o), 32'd1);

    // Clean read miss, memory ready every other cycle
    step();
    wen_i = 1'b0; ren_i = 1'b1; hit_i = 1'b0; dirty_i = 1'b0; addr_i = 32'h1234_5678;
    @(negedge clk_i);
    chk("miss_ctrl", 32'(control_o), 32'h01);
    chk("miss_ready", 32'(ready_o), 32'd0);
    chk("miss_strobes", 32'({mem_ren_o, mem_wen_o}), 32'd0);
    push_fill(32'h1234_5670);
    step();
    run_transfer(4, 20, 1'b1);
    hit_i = 1'b1;
    @(negedge clk_i);
    chk("retry_rd_ready", 32'(ready_o), 32'd1);
    chk("retry_rd_ctrl", 32'(control_o), 32'h03);
    chk("retry_rd_ren", 32'(mem_ren_o), 32'd0);

    // Dirty write miss: write back victim tag 3 / index 1, then refill
    step();
    ren_i = 1'b0; wen_i = 1'b1; hit_i = 1'b0; dirty_i = 1'b1;
    tag_i = 26'h3; addr_i = 32'hABCD_0014;
    @(negedge clk_i);
    chk("dmiss_ctrl", 32'(control_o), 32'h01);
    chk("dmiss_ready", 32'(ready_o), 32'd0);
    for (int w = 0; w < 4; w++) push(1'b1, 32'h0000_00D0 + 32'(w * 4), 6'b000000);
    push_fill(32'hABCD_0010);
    step();
    run_transfer(8, 24, 1'b0);
    hit_i = 1'b1; dirty_i = 1'b0;
    @(negedge clk_i);
    chk("retry_wr_ctrl", 32'(control_o), 32'h2F);
    chk("retry_wr_ready", 32'(ready_o), 32'd1);

    // Reset during the third refill word
    step();
    wen_i = 1'b0; ren_i = 1'b1; hit_i = 1'b0; addr_i = 32'h0000_0100;
    @(negedge clk_i);
    chk("rmiss_ctrl", 32'(control_o), 32'h01);
    push(1'b0, 32'h0000_0100, 6'b010000);
    push(1'b0, 32'h0000_0104, 6'b010000);
    step();
    run_transfer(2, 10, 1'b0);
    rst_i = 1'b1; mem_ready_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_ctrl", 32'(control_o), 32'd0);
    chk("midrst_ren", 32'(mem_ren_o), 32'd0);
    chk("midrst_ready", 32'(ready_o), 32'd0);
    step();
    rst_i = 1'b0; ren_i = 1'b0; mem_ready_i = 1'b0;
    @(negedge clk_i);
    chk("postrst_ctrl", 32'(control_o), 32'h01);
    chk("postrst_ren", 32'(mem_ren_o), 32'd0);
    chk("postrst_addr", mem_addr_o, 32'h0000_0100);
    step();
    ren_i = 1'b1;
    push_fill(32'h0000_0100);
    @(negedge clk_i);
    chk("restart_ctrl", 32'(control_o), 32'h01);
    step();
    run_transfer(4, 20, 1'b1);
    hit_i = 1'b1;
    @(negedge clk_i);
    chk("restart_ready", 32'(ready_o), 32'd1);
    chk("restart_hit_ctrl", 32'(control_o), 32'h03);

    step();
    ren_i = 1'b0; hit_i = 1'b0;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- FSM that sequences one cache `set` datapath on behalf of the processor port.
- Per request it produces the 6-bit set control word, stalls the processor on a miss, writes back a dirty victim line word-by-word, and refills the line from memory.
- Sits between the processor request port, the `set` instance (via control/hit/dirty/tag) and the memory bus.

Parameters:
- TAG_WIDTH, 26, tag bits of the address (addr[31:32-TAG_WIDTH]).
- INDEX_WIDTH, 2, set-index bits (addr[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH]).
- OFFSET_WIDTH, 4, byte-offset bits per line; WORDS = 2^(OFFSET_WIDTH-2). Requires TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH = 32.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- ren_i  in  1  processor read request.
- wen_i  in  1  processor write request; has priority if both are high.
- addr_i  in  32  processor address; held stable until ready_o.
- hit_i  in  1  set hit.
- dirty_i  in  1  dirty bit of the set-selected line.
- tag_i  in  TAG_WIDTH  tag of the set-selected line (the victim on a miss).
- mem_ready_i  in  1  memory accepted or returned one word this cycle.
- control_o  out  6  {write_en, update_en, set_valid, set_dirty, strategy_en, offset_sel} to the set.
- mem_addr_o  out  32  word address for the memory transfer; also drives the set's mem_addr_i.
- mem_ren_o  out  1  memory read strobe (refill).
- mem_wen_o  out  1  memory write strobe (write-back). Write data is the set's read_data_o, wired at top level.
- ready_o  out  1  request completes this cycle.

Behaviour:
- States: COMPARE, WRITE_BACK, ALLOCATE.
  - state register and word counter cnt (OFFSET_WIDTH-2 bits) are registered.
  - All outputs are combinational from state, cnt and inputs.
- Reset (rst_i=1 at an edge): state<=COMPARE, cnt<=0.
  - While rst_i is high, all outputs are forced to 0, including ready_o.
  - Reset mid-WRITE_BACK or mid-ALLOCATE abandons the transfer; the partially refilled line stays invalid.
- COMPARE, no request: control_o=6'b000001; ready_o=0; mem strobes 0.
- COMPARE, read hit: control_o=6'b000011 (strategy update); ready_o=1 in the same cycle (0-cycle latency).
- COMPARE, write hit: control_o=6'b101111 (write, valid, dirty, strategy, CPU offset); ready_o=1 in the same cycle.
- COMPARE, miss: control_o=6'b000001, ready_o=0.
  - dirty_i=1: next state WRITE_BACK.
  - dirty_i=0: next state ALLOCATE.
  - cnt<=0 in both cases.
- WRITE_BACK:
  - mem_addr_o={tag_i, addr_i index, cnt, 2'b00}; mem_wen_o=1; control_o=6'b000000 (memory offset so the set outputs word cnt).
  - On mem_ready_i: cnt<=cnt+1.
  - On mem_ready_i with cnt==WORDS-1: cnt wraps to 0, next state ALLOCATE.
  - strategy_en stays 0 throughout, so the victim selection stays stable.
- ALLOCATE:
  - mem_addr_o={addr_i tag, index, cnt, 2'b00}; mem_ren_o=1.
  - On mem_ready_i: control_o has update_en=1 (6'b010000 normally, 6'b011000 on the last word), cnt<=cnt+1.
  - set_valid is asserted only on the last word, so hit_i stays 0 and the victim mask stays fixed during the refill.
  - Without mem_ready_i: control_o=0.
  - After the last word: cnt=0, next state COMPARE. The retried request then hits; a write also merges its data there.
- mem_addr_o in COMPARE = {addr_i[31:OFFSET_WIDTH], OFFSET_WIDTH'b0}.
- Request dropped while stalled: the FSM still completes the current transfer, then idles in COMPARE.
- mem_ready_i is ignored in COMPARE.
- Miss to read completion = WORDS (write-back only if dirty) + WORDS refill handshakes + 1 compare cycle.

Test Plan:
- Reset held for 2 cycles with ren_i=1 -> control_o=0, ready_o=0, mem_ren_o=0; after release with idle inputs -> control_o=6'b000001, state COMPARE.
- ren_i=1, addr_i=32'h0000_0040, hit_i=1 -> ready_o=1 in the same cycle, control_o=6'b000011, no memory strobes.
- wen_i=1, hit_i=1 -> control_o=6'b101111, ready_o=1; ren_i=wen_i=1 together -> same write response.
- Clean read miss, addr_i=32'h1234_5678, mem_ready_i every other cycle -> mem_ren_o addresses 0x1234_5670, 74, 78, 7C in order.
  - update_en pulses only on ready cycles; set_valid only on the 0x7C word.
  - The next cycle is COMPARE; with hit_i=1, ready_o=1.
- Dirty write miss, tag_i=26'h3 with index 1 -> four mem_wen_o words at 0x0000_00D0..DC, then four refill reads, then write-hit control 6'b101111 with ready_o=1.
- rst_i asserted during the 3rd refill word -> next cycle is COMPARE, cnt=0, mem_ren_o=0; a new request restarts from word 0.
